// File: rtl/addsub_seq_if.sv
// Start/done handshake bundle for the multi-precision add/sub sequencer.
// The master drives requests and accepts results; the slave is the sequencer.
interface addsub_seq_if #(
  parameter int unsigned W = 32
);
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         sub;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] result;
  logic         ccc;
  logic         ccn;
  logic         ccz;
  logic         ccv;
  logic         busy;

  modport master (
    output start_valid, x, y, sub, done_ready,
    input  start_ready, done_valid, result, ccc, ccn, ccz, ccv, busy
  );

  modport slave (
    input  start_valid, x, y, sub, done_ready,
    output start_ready, done_valid, result, ccc, ccn, ccz, ccv, busy
  );
endinterface

// File: rtl/addsub_seq.sv
// Slice-serial add/subtract: one BITS-wide adder slice reused WORDS times,
// least significant slice first, with carry chained between cycles.
module addsub_seq #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_seq_if.slave  bus
);
  localparam int unsigned W    = BITS * WORDS;
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned SW   = BITS + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]    x_q;
  logic [W-1:0]    y_q;
  logic [W-1:0]    acc_q;
  logic            sub_q;
  logic            carry_q;
  logic            zero_q;
  logic [IDXW-1:0] idx_q;

  logic [W-1:0]    result_q;
  logic            ccc_q;
  logic            ccn_q;
  logic            ccz_q;
  logic            ccv_q;

  logic [BITS-1:0] xs;
  logic [BITS-1:0] ys_eff;
  logic [BITS-1:0] slice_sum;
  logic            slice_c;
  logic [W-1:0]    acc_next;
  logic            last;

  // Operands shift right each cycle, so the active slice is always the low one.
  always_comb begin
    xs       = x_q[BITS-1:0];
    ys_eff   = sub_q ? ~y_q[BITS-1:0] : y_q[BITS-1:0];
    {slice_c, slice_sum} = {1'b0, xs} + {1'b0, ys_eff} + SW'(carry_q);
    acc_next = {slice_sum, acc_q[W-1:BITS]};
    last     = (idx_q == IDXW'(WORDS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_valid) state_d = RUN;
      RUN:     if (last)            state_d = DONE;
      DONE:    if (bus.done_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready = 1'b0;
    bus.done_valid  = 1'b0;
    bus.busy        = 1'b1;
    case (state_q)
      IDLE: begin
        bus.start_ready = 1'b1;
        bus.busy        = 1'b0;
      end
      DONE:    bus.done_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath and result registers; results only move on the RUN->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      ccc_q    <= 1'b0;
      ccn_q    <= 1'b0;
      ccz_q    <= 1'b0;
      ccv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            x_q     <= bus.x;
            y_q     <= bus.y;
            sub_q   <= bus.sub;
            carry_q <= bus.sub;
            acc_q   <= '0;
            zero_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        RUN: begin
          x_q     <= x_q >> BITS;
          y_q     <= y_q >> BITS;
          acc_q   <= acc_next;
          carry_q <= slice_c;
          zero_q  <= zero_q & (slice_sum == '0);
          if (!last) begin
            idx_q <= idx_q + IDXW'(1);
          end else begin
            // Final slice holds the operand sign bits for the overflow check.
            result_q <= acc_next;
            ccc_q    <= slice_c;
            ccn_q    <= sub_q & ~slice_c;
            ccz_q    <= zero_q & (slice_sum == '0);
            ccv_q    <= (xs[BITS-1] == (y_q[BITS-1] ^ sub_q)) &&
                        (slice_sum[BITS-1] != xs[BITS-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ccc    = ccc_q;
  assign bus.ccn    = ccn_q;
  assign bus.ccz    = ccz_q;
  assign bus.ccv    = ccv_q;
endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Byte-serial multi-precision add/subtract sequencer. It takes wide operands through a valid/ready start handshake and processes them one BITS-wide slice per cycle, least significant slice first, through a single internal BITS-bit adder slice with carry chaining. It then presents the full-width result and condition codes (ccc, ccn, ccz, ccv) through a valid/ready done handshake. It lets the datapath do 16/32/64-bit arithmetic while reusing the 8-bit add/sub slice.

Parameters:
BITS, 8, width of one adder slice
WORDS, 4, number of slices per operand; total operand width W = BITS*WORDS (WORDS >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start_valid  input  1  operation request
start_ready  output  1  block can accept a request
x  input  W  operand A, sampled on start handshake
y  input  W  operand B, sampled on start handshake
sub  input  1  1 = x-y, 0 = x+y; sampled on start handshake
done_valid  output  1  result and flags valid
done_ready  input  1  consumer accepts result
result  output  W  final sum/difference, modulo 2^W
ccc  output  1  carry out; for sub, 1 = no borrow (x >= y unsigned)
ccn  output  1  sub && (x < y unsigned); 0 for add
ccz  output  1  result == 0
ccv  output  1  two's-complement signed overflow
busy  output  1  state != IDLE

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n), no synchronous reset.
- Reset (any time, including mid-RUN): state=IDLE, slice index=0, internal operand/accumulator/carry regs=0. Outputs: result=0, ccc=ccn=ccz=ccv=0, done_valid=0, busy=0, start_ready=1 after deassertion. An in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid at an edge: latch x, y, sub; set carry=sub (two's complement, x + ~y + 1); idx=0; go to RUN.
  - result and flags hold their previous values.
- RUN:
  - start_ready=0. Each edge computes {c, s} = x[idx] + (sub ? ~y[idx] : y[idx]) + carry.
  - Writes s into accumulator slice idx, sets carry<=c, idx<=idx+1.
  - Zero is tracked as the running AND of (s==0) over slices.
  - On idx==WORDS-1 edge: go to DONE and load the outputs:
    - result = accumulator, including the final slice.
    - ccc = final carry out.
    - ccn = sub & ~final carry out.
    - ccz = all slices zero.
    - ccv = (xmsb == ymsb_eff) & (rmsb != xmsb), where ymsb_eff = y[W-1]^sub.
  - Slice index is never advanced past WORDS-1.
- Latency: if the start handshake occurs at edge 0, slices are computed at edges 1..WORDS and done_valid is high after edge WORDS.
- DONE:
  - done_valid=1; result and flags stable while done_valid && !done_ready.
  - On done_ready at an edge: go to IDLE, done_valid=0. result and flags keep their values.
  - start_valid is ignored in RUN and DONE; no request is queued.
  - The earliest next accept is the edge after done is taken.
- Outputs result/ccc/ccn/ccz/ccv change only on the RUN->DONE edge or on reset.
- start_ready = (state==IDLE); it is combinational from state only, with no path from start_valid.
- x, y, sub may change freely after acceptance without affecting the operation.

Test Plan:
- Carry propagation: add x=0x000000FF, y=0x00000001 -> result 0x00000100, ccc=0 ccn=0 ccz=0 ccv=0. done_valid rises exactly 4 clocks after the accept edge.
- Wrap to zero: add x=0xFFFFFFFF, y=0x00000001 -> result 0x00000000, ccc=1 ccz=1 ccn=0 ccv=0. Also sub x=y=0x12345678 -> result 0, ccc=1 ccz=1 ccn=0.
- Borrow: sub x=5, y=7 -> result 0xFFFFFFFE, ccc=0 ccn=1 ccz=0 ccv=0.
- Signed overflow:
  - add 0x7FFFFFFF+0x00000001 -> 0x80000000, ccv=1 ccc=0.
  - sub 0x80000000-0x00000001 -> 0x7FFFFFFF, ccv=1 ccc=1 ccn=0.
- Backpressure: hold done_ready=0 for 3 cycles after done_valid while pulsing start_valid with new operands.
  - result and flags stay stable; start_ready=0; the new request is not taken.
  - After done_ready=1 the FSM returns to IDLE, and the next start is accepted one edge later.
- Reset mid-operation: assert rst_n=0 asynchronously after 2 slices of RUN.
  - All outputs go to 0 immediately, with no clock edge needed.
  - After release: busy=0, start_ready=1; a fresh add 3+4 yields 7 with correct latency.
